mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage_pkg.sv | 69 ++++++
 rtl/mem_access_stage_if.sv | 44 ++++
 rtl/mem_access_stage_load_store_align.sv | 50 +++++
 rtl/mem_access_stage.sv | 148 ++++++++++++++
 tb/tb_mem_access_stage.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared pipeline codes: ALU ops, opcodes, load/store types, MEM FSM states
package mem_access_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    ST_SB   = 2'b00,
    ST_SH   = 2'b01,
    ST_SW   = 2'b10,
    ST_NONE = 2'b11
  } store_type_e;

  typedef enum logic [2:0] {
    LD_LB   = 3'b000,
    LD_LH   = 3'b001,
    LD_LW   = 3'b010,
    LD_LBU  = 3'b011,
    LD_LHU  = 3'b100,
    LD_NONE = 3'b111
  } load_type_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } mem_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  function automatic logic is_store(input logic [1:0] st);
    return st != ST_NONE;
  endfunction

  // Unused load codes (101, 110) are treated as "no load".
  function automatic logic is_load(input logic [2:0] lt);
    return (lt == LD_LB) || (lt == LD_LH) || (lt == LD_LW) ||
           (lt == LD_LBU) || (lt == LD_LHU);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] st, input logic [2:0] lt,
                                         input logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    if (is_store(st)) begin
      if (st == ST_SH)      r = addr_lo[0];
      else if (st == ST_SW) r = (addr_lo != 2'b00);
    end else begin
      if ((lt == LD_LH) || (lt == LD_LHU)) r = addr_lo[0];
      else if (lt == LD_LW)                r = (addr_lo != 2'b00);
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - EX-side, data-memory and write-back signals of the MEM stage
interface mem_access_stage_if;

  logic        ex_valid;
  logic        pipeline_flush;
  logic [31:0] ex_result_alu;
  logic [31:0] ex_store_data;
  logic [1:0]  ex_store_type;
  logic [2:0]  ex_load_type;
  logic [4:0]  ex_wb_rd;
  logic        ex_wb_reg_file;

  logic        mem_stall;
  logic [31:0] data_forward_mem;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_file;
  logic        mem_fault;

  modport slave (
    input  ex_valid, pipeline_flush, ex_result_alu, ex_store_data, ex_store_type,
           ex_load_type, ex_wb_rd, ex_wb_reg_file, dmem_ready, dmem_rdata,
    output mem_stall, data_forward_mem, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           dmem_be, wb_valid, wb_data, wb_rd, wb_reg_file, mem_fault
  );

  modport master (
    output ex_valid, pipeline_flush, ex_result_alu, ex_store_data, ex_store_type,
           ex_load_type, ex_wb_rd, ex_wb_reg_file, dmem_ready, dmem_rdata,
    input  mem_stall, data_forward_mem, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           dmem_be, wb_valid, wb_data, wb_rd, wb_reg_file, mem_fault
  );

endinterface

// File: rtl/mem_access_stage_load_store_align.sv
// rtl/mem_access_stage_load_store_align.sv - byte enables, store lane replication and load extraction
module load_store_align
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_store_type,
  input  logic [2:0]  i_load_type,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [31:0] w_rd_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_store_data;
    case (store_type_e'(i_store_type))
      ST_SB: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_store_data[7:0]}};
      end
      ST_SH: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_store_data[15:0]}};
      end
      ST_SW:   o_be = 4'b1111;
      default: o_be = 4'b0000;
    endcase
  end

  always_comb begin
    w_rd_shift  = i_rdata >> {i_addr_lo, 3'b000};
    w_byte      = w_rd_shift[7:0];
    w_half      = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_load_data = i_rdata;
    case (load_type_e'(i_load_type))
      LD_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  o_load_data = {24'd0, w_byte};
      LD_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      LD_LHU:  o_load_data = {16'd0, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - EX/MEM register, data-memory access FSM with timeout, MEM/WB register
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic                clk,
  input logic                rst,
  mem_access_stage_if.slave  bus
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

  mem_state_e  r_state;
  mem_state_e  w_next_state;
  logic [7:0]  r_cnt;

  logic        r_m_valid;
  logic [31:0] r_m_alu;
  logic [31:0] r_m_store_data;
  logic [1:0]  r_m_store_type;
  logic [2:0]  r_m_load_type;
  logic [4:0]  r_m_rd;
  logic        r_m_reg_file;

  logic        r_wb_valid;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_rd;
  logic        r_wb_reg_file;

  logic        w_m_store;
  logic        w_m_load;
  logic        w_m_misaligned;
  logic        w_timeout;
  logic        w_ex_go;
  logic        w_stall;
  logic        w_req;
  logic        w_fault;
  logic        w_retire;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  load_store_align u_align (
    .i_addr_lo    (r_m_alu[1:0]),
    .i_store_type (r_m_store_type),
    .i_load_type  (r_m_load_type),
    .i_store_data (r_m_store_data),
    .i_rdata      (bus.dmem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  assign w_m_store      = is_store(r_m_store_type);
  assign w_m_load       = ~w_m_store & is_load(r_m_load_type);
  assign w_m_misaligned = r_m_valid & (w_m_store | w_m_load) &
                          is_misaligned(r_m_store_type, r_m_load_type, r_m_alu[1:0]);
  assign w_timeout      = (r_state == S_ACCESS) && (r_cnt == LP_TIMEOUT);
  // Only an aligned memory op in the instruction about to be captured opens an access.
  assign w_ex_go        = bus.ex_valid & ~bus.pipeline_flush &
                          (is_store(bus.ex_store_type) | is_load(bus.ex_load_type)) &
                          ~is_misaligned(bus.ex_store_type, bus.ex_load_type,
                                         bus.ex_result_alu[1:0]);
  assign w_retire       = r_m_valid & ~w_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_req        = 1'b0;
    w_fault      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_fault      = w_m_misaligned;
        w_next_state = w_ex_go ? S_ACCESS : S_IDLE;
      end
      S_ACCESS: begin
        w_req   = ~w_timeout;
        w_fault = w_timeout;
        w_stall = ~bus.dmem_ready & ~w_timeout;
        if (!w_stall) w_next_state = w_ex_go ? S_ACCESS : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_cnt <= 8'd0;
    else if (r_state == S_ACCESS && w_stall) r_cnt <= r_cnt + 8'd1;
    else                                    r_cnt <= 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid      <= 1'b0;
      r_m_alu        <= 32'd0;
      r_m_store_data <= 32'd0;
      r_m_store_type <= ST_NONE;
      r_m_load_type  <= LD_NONE;
      r_m_rd         <= 5'd0;
      r_m_reg_file   <= 1'b0;
    end else if (!w_stall) begin
      r_m_valid      <= bus.ex_valid & ~bus.pipeline_flush;
      r_m_alu        <= bus.ex_result_alu;
      r_m_store_data <= bus.ex_store_data;
      r_m_store_type <= bus.ex_store_type;
      r_m_load_type  <= bus.ex_load_type;
      r_m_rd         <= bus.ex_wb_rd;
      r_m_reg_file   <= bus.ex_wb_reg_file;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid    <= 1'b0;
      r_wb_data     <= 32'd0;
      r_wb_rd       <= 5'd0;
      r_wb_reg_file <= 1'b0;
    end else if (w_stall) begin
      r_wb_valid    <= 1'b0;
      r_wb_reg_file <= 1'b0;
    end else begin
      r_wb_valid    <= w_retire;
      r_wb_data     <= w_m_load ? w_load_data : r_m_alu;
      r_wb_rd       <= r_m_rd;
      r_wb_reg_file <= w_retire & r_m_reg_file & ~w_m_store & (r_m_rd != 5'd0);
    end
  end

  assign bus.mem_stall        = w_stall;
  assign bus.mem_fault        = w_fault;
  assign bus.data_forward_mem = r_m_alu;
  assign bus.dmem_req         = w_req;
  assign bus.dmem_we          = w_req & w_m_store;
  assign bus.dmem_be          = w_req ? w_be : 4'b0000;
  assign bus.dmem_addr        = {r_m_alu[31:2], 2'b00};
  assign bus.dmem_wdata       = w_wdata;
  assign bus.wb_valid         = r_wb_valid;
  assign bus.wb_data          = r_wb_data;
  assign bus.wb_rd            = r_wb_rd;
  assign bus.wb_reg_file      = r_wb_reg_file;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage (TIMEOUT_CYCLES=4)
module tb_mem_access_stage;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rf;
  } wb_exp_t;

  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          delay;
  } st_vec_t;

  typedef struct packed {
    logic [2:0]  lt;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
    int          delay;
  } ld_vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  wb_exp_t wb_q[$];

  always #5 clk = ~clk;

  mem_access_stage_if bus_if();

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always @(negedge clk) begin
    wb_exp_t e;
    if (rst === 1'b0 && bus_if.wb_valid === 1'b1) begin
      n_checks++;
      if (wb_q.size() == 0) begin
        n_errors++;
        $display("FAIL wb_unexpected: got data=%h rd=%0d rf=%b, required no retire",
                 bus_if.wb_data, bus_if.wb_rd, bus_if.wb_reg_file);
      end else begin
        e = wb_q.pop_front();
        if (bus_if.wb_data !== e.data || bus_if.wb_rd !== e.rd || bus_if.wb_reg_file !== e.rf) begin
          n_errors++;
          $display("FAIL wb_retire: got data=%h rd=%0d rf=%b, required data=%h rd=%0d rf=%b",
                   bus_if.wb_data, bus_if.wb_rd, bus_if.wb_reg_file, e.data, e.rd, e.rf);
        end
      end
    end
  end

  task automatic drive_ex(input logic v, input logic fl, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [1:0] st, input logic [2:0] lt,
                          input logic [4:0] rd, input logic rf);
    bus_if.ex_valid       = v;
    bus_if.pipeline_flush = fl;
    bus_if.ex_result_alu  = alu;
    bus_if.ex_store_data  = sd;
    bus_if.ex_store_type  = st;
    bus_if.ex_load_type   = lt;
    bus_if.ex_wb_rd       = rd;
    bus_if.ex_wb_reg_file = rf;
  endtask

  task automatic drive_bubble();
    drive_ex(1'b0, 1'b0, 32'd0, 32'd0, 2'b11, 3'b111, 5'd0, 1'b0);
  endtask

  // Memory responder: ready after wait_cycles non-ready cycles; returns at the next negedge.
  task automatic serve(input int wait_cycles, input logic [31:0] rdata,
                       output int stalls, output int reqs);
    stalls = 0;
    reqs   = 0;
    for (int c = 0; c <= wait_cycles; c++) begin
      bus_if.dmem_ready = (c == wait_cycles);
      bus_if.dmem_rdata = (c == wait_cycles) ? rdata : 32'hDEAD_BEEF;
      #1;
      if (bus_if.mem_stall === 1'b1) stalls++;
      if (bus_if.dmem_req === 1'b1) reqs++;
      @(negedge clk);
    end
    bus_if.dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [46:0] v;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    v = {bus_if.mem_stall, bus_if.dmem_req, bus_if.dmem_we, bus_if.dmem_be, bus_if.wb_valid,
         bus_if.wb_reg_file, bus_if.wb_data, bus_if.wb_rd, bus_if.mem_fault};
    n_checks++;
    if (v !== 47'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h, required 0", v);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 32'h1234, 32'd0, 2'b11, 3'b111, 5'd5, 1'b1);
    wb_q.push_back(wb_exp_t'{32'h1234, 5'd5, 1'b1});
    @(negedge clk);
    drive_bubble();
    n_checks++;
    if (bus_if.mem_stall !== 1'b0 || bus_if.data_forward_mem !== 32'h1234) begin
      n_errors++;
      $display("FAIL alu_mslot: got stall=%b fwd=%h, required stall=0 fwd=00001234",
               bus_if.mem_stall, bus_if.data_forward_mem);
    end
    @(negedge clk);
    n_checks++;
    if (bus_if.wb_valid !== 1'b1 || bus_if.wb_data !== 32'h1234) begin
      n_errors++;
      $display("FAIL alu_latency: got valid=%b data=%h, required valid=1 data=00001234",
               bus_if.wb_valid, bus_if.wb_data);
    end
    drive_ex(1'b1, 1'b0, 32'h55, 32'd0, 2'b11, 3'b111, 5'd0, 1'b1);
    wb_q.push_back(wb_exp_t'{32'h55, 5'd0, 1'b0});
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 32'h77, 32'd0, 2'b11, 3'b111, 5'd6, 1'b1);
    @(negedge clk);
    drive_bubble();
    n_checks++;
    if (bus_if.wb_valid !== 1'b1 || bus_if.wb_reg_file !== 1'b0) begin
      n_errors++;
      $display("FAIL rd0_force: got valid=%b rf=%b, required valid=1 rf=0",
               bus_if.wb_valid, bus_if.wb_reg_file);
    end
    @(negedge clk);
    n_checks++;
    if (bus_if.wb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_bubble: got wb_valid=%b, required 0", bus_if.wb_valid);
    end
  endtask

  task automatic test_stores();
    st_vec_t tbl[4];
    int stalls, reqs;
    tbl[0] = '{2'b00, 32'h0000_0103, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 3};
    tbl[1] = '{2'b01, 32'h0000_0202, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF, 0};
    tbl[2] = '{2'b10, 32'h0000_0308, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1};
    tbl[3] = '{2'b00, 32'h0000_0100, 32'h1111_115A, 4'b0001, 32'h5A5A_5A5A, 0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_ex(1'b1, 1'b0, tbl[i].addr, tbl[i].data, tbl[i].st, 3'b111, 5'd9, 1'b1);
      wb_q.push_back(wb_exp_t'{tbl[i].addr, 5'd9, 1'b0});
      @(negedge clk);
      drive_bubble();
      n_checks++;
      if (bus_if.dmem_req !== 1'b1 || bus_if.dmem_we !== 1'b1 || bus_if.dmem_be !== tbl[i].be ||
          bus_if.dmem_wdata !== tbl[i].wdata || bus_if.dmem_addr !== {tbl[i].addr[31:2], 2'b00}) begin
        n_errors++;
        $display("FAIL store_req[%0d]: got req=%b we=%b be=%b wdata=%h addr=%h, required req=1 we=1 be=%b wdata=%h addr=%h",
                 i, bus_if.dmem_req, bus_if.dmem_we, bus_if.dmem_be, bus_if.dmem_wdata,
                 bus_if.dmem_addr, tbl[i].be, tbl[i].wdata, {tbl[i].addr[31:2], 2'b00});
      end
      serve(tbl[i].delay, 32'd0, stalls, reqs);
      n_checks++;
      if (stalls != tbl[i].delay || reqs != tbl[i].delay + 1) begin
        n_errors++;
        $display("FAIL store_stall[%0d]: got stalls=%0d reqs=%0d, required stalls=%0d reqs=%0d",
                 i, stalls, reqs, tbl[i].delay, tbl[i].delay + 1);
      end
    end
  endtask

  task automatic test_loads();
    ld_vec_t tbl[5];
    int stalls, reqs;
    tbl[0] = '{3'b000, 32'h0000_0002, 32'h0080_0000, 32'hFFFF_FF80, 0};
    tbl[1] = '{3'b100, 32'h0000_0002, 32'h8000_0000, 32'h0000_8000, 1};
    tbl[2] = '{3'b001, 32'h0000_0004, 32'h0000_8001, 32'hFFFF_8001, 0};
    tbl[3] = '{3'b011, 32'h0000_0007, 32'hF000_0000, 32'h0000_00F0, 2};
    tbl[4] = '{3'b010, 32'h0000_0008, 32'h1234_5678, 32'h1234_5678, 0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_ex(1'b1, 1'b0, tbl[i].addr, 32'hFFFF_FFFF, 2'b11, tbl[i].lt, 5'(10 + i), 1'b1);
      wb_q.push_back(wb_exp_t'{tbl[i].exp, 5'(10 + i), 1'b1});
      @(negedge clk);
      drive_bubble();
      n_checks++;
      if (bus_if.dmem_req !== 1'b1 || bus_if.dmem_we !== 1'b0 ||
          bus_if.dmem_addr !== {tbl[i].addr[31:2], 2'b00}) begin
        n_errors++;
        $display("FAIL load_req[%0d]: got req=%b we=%b addr=%h, required req=1 we=0 addr=%h",
                 i, bus_if.dmem_req, bus_if.dmem_we, bus_if.dmem_addr, {tbl[i].addr[31:2], 2'b00});
      end
      serve(tbl[i].delay, tbl[i].rdata, stalls, reqs);
      n_checks++;
      if (stalls != tbl[i].delay) begin
        n_errors++;
        $display("FAIL load_stall[%0d]: got %0d, required %0d", i, stalls, tbl[i].delay);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]  st[4] = '{2'b11, 2'b01, 2'b11, 2'b10};
    logic [2:0]  lt[4] = '{3'b010, 3'b111, 3'b100, 3'b111};
    logic [31:0] ad[4] = '{32'h6, 32'h1, 32'h3, 32'h2};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_ex(1'b1, 1'b0, ad[i], 32'h0, st[i], lt[i], 5'd4, 1'b1);
      @(negedge clk);
      drive_bubble();
      n_checks++;
      if (bus_if.dmem_req !== 1'b0 || bus_if.mem_fault !== 1'b1 || bus_if.mem_stall !== 1'b0) begin
        n_errors++;
        $display("FAIL misalign[%0d]: got req=%b fault=%b stall=%b, required req=0 fault=1 stall=0",
                 i, bus_if.dmem_req, bus_if.mem_fault, bus_if.mem_stall);
      end
      @(negedge clk);
      n_checks++;
      if (bus_if.mem_fault !== 1'b0 || bus_if.wb_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL misalign_after[%0d]: got fault=%b wb_valid=%b, required 0 0",
                 i, bus_if.mem_fault, bus_if.wb_valid);
      end
    end
  endtask

  task automatic test_timeout();
    int   stalls = 0;
    int   fault_at = -1;
    logic req_at_fault = 1'b1;
    logic stall_at_fault = 1'b1;
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 3'b010, 5'd8, 1'b1);
    @(negedge clk);
    drive_bubble();
    for (int c = 0; c < 10; c++) begin
      if (bus_if.mem_fault === 1'b1) begin
        fault_at       = c;
        req_at_fault   = bus_if.dmem_req;
        stall_at_fault = bus_if.mem_stall;
        break;
      end
      if (bus_if.mem_stall === 1'b1) stalls++;
      @(negedge clk);
    end
    n_checks++;
    if (fault_at != 4 || stalls != 4 || req_at_fault !== 1'b0 || stall_at_fault !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout: got fault_at=%0d stalls=%0d req=%b stall=%b, required 4 4 0 0",
               fault_at, stalls, req_at_fault, stall_at_fault);
    end
    @(negedge clk);
    n_checks++;
    if (bus_if.mem_fault !== 1'b0 || bus_if.mem_stall !== 1'b0 ||
        bus_if.dmem_req !== 1'b0 || bus_if.wb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_after: got fault=%b stall=%b req=%b wb_valid=%b, required all 0",
               bus_if.mem_fault, bus_if.mem_stall, bus_if.dmem_req, bus_if.wb_valid);
    end
  endtask

  task automatic test_flush_in_access();
    int stalls, reqs;
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 3'b010, 5'd11, 1'b1);
    wb_q.push_back(wb_exp_t'{32'hA5A5_A5A5, 5'd11, 1'b1});
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 32'h99, 32'h0, 2'b11, 3'b111, 5'd12, 1'b1);
    serve(2, 32'hA5A5_A5A5, stalls, reqs);
    drive_bubble();
    n_checks++;
    if (stalls != 2 || reqs != 3) begin
      n_errors++;
      $display("FAIL flush_access: got stalls=%0d reqs=%0d, required 2 3", stalls, reqs);
    end
    @(negedge clk);
    n_checks++;
    if (bus_if.wb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_held: got wb_valid=%b, required 0", bus_if.wb_valid);
    end
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    bus_if.dmem_ready = 1'b1;
    bus_if.dmem_rdata = 32'h0000_00FF;
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 32'h11, 32'h0, 2'b11, 3'b111, 5'd1, 1'b1);
    wb_q.push_back(wb_exp_t'{32'h11, 5'd1, 1'b1});
    @(negedge clk);
    if (bus_if.mem_stall === 1'b1) stalls++;
    drive_ex(1'b1, 1'b0, 32'h0, 32'h0, 2'b11, 3'b011, 5'd2, 1'b1);
    wb_q.push_back(wb_exp_t'{32'hFF, 5'd2, 1'b1});
    @(negedge clk);
    if (bus_if.mem_stall === 1'b1) stalls++;
    drive_ex(1'b1, 1'b0, 32'h22, 32'h0, 2'b11, 3'b111, 5'd3, 1'b1);
    wb_q.push_back(wb_exp_t'{32'h22, 5'd3, 1'b1});
    @(negedge clk);
    if (bus_if.mem_stall === 1'b1) stalls++;
    drive_ex(1'b1, 1'b0, 32'h40, 32'h7, 2'b10, 3'b111, 5'd4, 1'b1);
    wb_q.push_back(wb_exp_t'{32'h40, 5'd4, 1'b0});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus_if.mem_stall === 1'b1) stalls++;
      drive_bubble();
    end
    bus_if.dmem_ready = 1'b0;
    n_checks++;
    if (stalls != 0 || wb_q.size() != 0) begin
      n_errors++;
      $display("FAIL back_to_back: got stalls=%0d pending=%0d, required 0 0", stalls, wb_q.size());
    end
  endtask

  task automatic test_reset_mid_access();
    logic [79:0] v;
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 32'h24, 32'h1, 2'b10, 3'b111, 5'd5, 1'b1);
    @(negedge clk);
    drive_bubble();
    n_checks++;
    if (bus_if.dmem_req !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_pre_req: got %b, required 1", bus_if.dmem_req);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    v = {bus_if.dmem_req, bus_if.dmem_we, bus_if.dmem_be, bus_if.mem_stall, bus_if.mem_fault,
         bus_if.wb_valid, bus_if.wb_reg_file, bus_if.wb_rd, bus_if.wb_data, bus_if.data_forward_mem};
    n_checks++;
    if (v !== 80'd0) begin
      n_errors++;
      $display("FAIL rst_mid_access: got %h, required 0", v);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus_if.dmem_req !== 1'b0 || bus_if.mem_stall !== 1'b0 || bus_if.wb_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_discard: got req=%b stall=%b wb_valid=%b, required 0 0 0",
               bus_if.dmem_req, bus_if.mem_stall, bus_if.wb_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst               = 1'b1;
    bus_if.dmem_ready = 1'b0;
    bus_if.dmem_rdata = 32'd0;
    drive_bubble();
    test_reset();
    test_alu();
    test_stores();
    test_loads();
    test_misaligned();
    test_timeout();
    test_flush_in_access();
    test_back_to_back();
    test_reset_mid_access();
    repeat (2) @(negedge clk);
    n_checks++;
    if (wb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", wb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
